// File: rtl/fetch_stage_if.sv
`default_nettype none
// ============================================================================
// Module   : fetch_stage_if
// Brief    : Instruction-memory request/return and fetch-to-decode handshake.
// Revision : 1.0 - initial release
// ============================================================================
interface fetch_stage_if #(
    parameter int ADDR_W = 32
);
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_rdata;
    logic              if_valid;
    logic              if_ready;
    logic [31:0]       if_instr;
    logic [ADDR_W-1:0] if_pc;

    modport master (
        output imem_req, imem_addr, if_valid, if_instr, if_pc,
        input  imem_rdata, if_ready
    );

    modport slave (
        input  imem_req, imem_addr, if_valid, if_instr, if_pc,
        output imem_rdata, if_ready
    );
endinterface
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : fetch_stage
// Brief    : PC owner, 1-cycle imem fetch, 2-entry skid FIFO, branch redirect.
//            Optional FETCH_PERF_EN adds fetch/redirect event counters.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_stage #(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int                PC_STEP  = 4
) (
    input  wire logic              clk,
    input  wire logic              rst,
    input  wire logic              br_resolve,
    input  wire logic              change_pc,
    input  wire logic [ADDR_W-1:0] br_target,
    fetch_stage_if.master          bus,
`ifdef FETCH_PERF_EN
    output logic [31:0]            perf_fetch_cnt,
    output logic [31:0]            perf_redirect_cnt,
`endif
    output logic                   fetch_err
);
    localparam logic [0:0] S_RUN  = 1'b0;
    localparam logic [0:0] S_HALT = 1'b1;

    logic [0:0]        r_state;
    logic [0:0]        w_state_nxt;
    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] r_ret_pc;
    logic              r_inflight;
    logic [1:0]        r_count;
    logic [31:0]       r_instr0;
    logic [31:0]       r_instr1;
    logic [ADDR_W-1:0] r_pc0;
    logic [ADDR_W-1:0] r_pc1;

    logic              w_run;
    logic              w_taken;
    logic              w_valid;
    logic              w_pop;
    logic [2:0]        w_level;
    logic              w_req;
    logic              w_ret;
    logic              w_store;
    logic              w_drain;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_RUN;
        else     r_state <= w_state_nxt;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_RUN:   if (w_taken && (br_target[1:0] != 2'b00)) w_state_nxt = S_HALT;
            S_HALT:  w_state_nxt = S_HALT;
            default: w_state_nxt = S_RUN;
        endcase
    end

    // ---------------- FSM: outputs / control ----------------
    always_comb begin
        w_run     = (r_state == S_RUN) && !rst;
        fetch_err = (r_state == S_HALT);
        w_taken   = w_run && br_resolve && change_pc;
        // The word returning this cycle is visible to decode through a bypass,
        // so the head may be valid while the FIFO storage is still empty.
        w_valid   = w_run && ((r_count != 2'd0) || r_inflight);
        w_pop     = w_valid && bus.if_ready;
        w_level   = {1'b0, r_count} + {2'b00, r_inflight} - {2'b00, w_pop};
        w_req     = w_run && !w_taken && (w_level < 3'd2);
        w_ret     = r_inflight && w_run && !w_taken;
        w_store   = w_ret && !((r_count == 2'd0) && w_pop);
        w_drain   = w_pop && (r_count != 2'd0);
    end

    assign bus.imem_req  = w_req;
    assign bus.imem_addr = r_pc;
    assign bus.if_valid  = w_valid;
    assign bus.if_instr  = (r_count == 2'd0) ? bus.imem_rdata : r_instr0;
    assign bus.if_pc     = (r_count == 2'd0) ? r_ret_pc : r_pc0;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc <= RESET_PC;
        end else if (w_taken) begin
            r_pc <= br_target;
        end else if (w_req) begin
            r_pc <= r_pc + ADDR_W'(PC_STEP);
        end
    end

    always_ff @(posedge clk) begin
        if (rst || (r_state == S_HALT) || w_taken) begin
            r_count    <= 2'd0;
            r_inflight <= 1'b0;
        end else begin
            r_inflight <= w_req;
            case ({w_store, w_drain})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage shifts toward slot 0 so slot 0 is always the head.
    always_ff @(posedge clk) begin
        if (w_req) r_ret_pc <= r_pc;
        case ({w_store, w_drain})
            2'b10: begin
                if (r_count == 2'd0) begin
                    r_instr0 <= bus.imem_rdata;
                    r_pc0    <= r_ret_pc;
                end else begin
                    r_instr1 <= bus.imem_rdata;
                    r_pc1    <= r_ret_pc;
                end
            end
            2'b01: begin
                r_instr0 <= r_instr1;
                r_pc0    <= r_pc1;
            end
            2'b11: begin
                if (r_count == 2'd1) begin
                    r_instr0 <= bus.imem_rdata;
                    r_pc0    <= r_ret_pc;
                end else begin
                    r_instr0 <= r_instr1;
                    r_pc0    <= r_pc1;
                    r_instr1 <= bus.imem_rdata;
                    r_pc1    <= r_ret_pc;
                end
            end
            default: ;
        endcase
    end

`ifdef FETCH_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_fetch_cnt    <= 32'd0;
            perf_redirect_cnt <= 32'd0;
        end else begin
            if (w_ret)   perf_fetch_cnt    <= perf_fetch_cnt + 32'd1;
            if (w_taken) perf_redirect_cnt <= perf_redirect_cnt + 32'd1;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_stage
// Brief    : Directed self-checking bench for fetch_stage (addr-as-data imem).
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_stage;
    logic        clk;
    logic        rst;
    logic        br_resolve;
    logic        change_pc;
    logic [31:0] br_target;
    logic        fetch_err;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetch_cnt;
    logic [31:0] perf_redirect_cnt;
`endif

    int n_vec;
    int n_err;

    fetch_stage_if #(.ADDR_W(32)) bus ();

    fetch_stage #(.ADDR_W(32), .RESET_PC(32'h0), .PC_STEP(4)) dut (
        .clk               (clk),
        .rst               (rst),
        .br_resolve        (br_resolve),
        .change_pc         (change_pc),
        .br_target         (br_target),
        .bus               (bus.master),
`ifdef FETCH_PERF_EN
        .perf_fetch_cnt    (perf_fetch_cnt),
        .perf_redirect_cnt (perf_redirect_cnt),
`endif
        .fetch_err         (fetch_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory returns the request address as the instruction word.
    always @(posedge clk)
        bus.imem_rdata <= bus.imem_req ? bus.imem_addr : 32'hBAD0_BAD0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic cyc;
        @(negedge clk);
    endtask

    // Inputs are set right after a negedge; outputs are checked 1 time unit later.
    task automatic set_in(input logic r, input logic rdy, input logic br,
                          input logic cp, input logic [31:0] tgt);
        rst          = r;
        bus.if_ready = rdy;
        br_resolve   = br;
        change_pc    = cp;
        br_target    = tgt;
        #1;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        set_in(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        cyc;

        // Reset state
        set_in(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        chk("rst_req",   {31'd0, bus.imem_req}, 32'd0);
        chk("rst_valid", {31'd0, bus.if_valid}, 32'd0);
        chk("rst_err",   {31'd0, fetch_err},    32'd0);
        cyc;

        // Startup stream: one word per cycle, first if_valid one cycle after first req
        for (int i = 0; i < 6; i++) begin
            set_in(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
            chk("st_req",   {31'd0, bus.imem_req}, 32'd1);
            chk("st_addr",  bus.imem_addr, 32'(4 * i));
            chk("st_valid", {31'd0, bus.if_valid}, (i == 0) ? 32'd0 : 32'd1);
            if (i > 0) begin
                chk("st_pc",    bus.if_pc,    32'(4 * (i - 1)));
                chk("st_instr", bus.if_instr, 32'(4 * (i - 1)));
            end
            cyc;
        end

        // Stall: head 0x14 held, one more request, then FIFO full and requests stop
        for (int s = 0; s < 5; s++) begin
            set_in(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
            chk("stall_valid", {31'd0, bus.if_valid}, 32'd1);
            chk("stall_pc",    bus.if_pc,    32'h14);
            chk("stall_instr", bus.if_instr, 32'h14);
            chk("stall_req",   {31'd0, bus.imem_req}, (s == 0) ? 32'd1 : 32'd0);
            cyc;
        end
        // Release: in order, no gap or duplicate
        for (int r = 0; r < 4; r++) begin
            set_in(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
            chk("rel_valid", {31'd0, bus.if_valid}, 32'd1);
            chk("rel_pc",    bus.if_pc,    32'(32'h14 + 4 * r));
            chk("rel_instr", bus.if_instr, 32'(32'h14 + 4 * r));
            chk("rel_req",   {31'd0, bus.imem_req}, 32'd1);
            chk("rel_addr",  bus.imem_addr, 32'(32'h1C + 4 * r));
            cyc;
        end

        // Taken redirect to 0x100 with one word buffered and one in flight
        set_in(1'b0, 1'b0, 1'b1, 1'b1, 32'h100);
        chk("br_pre_pc", bus.if_pc, 32'h24);
        chk("br_req0",   {31'd0, bus.imem_req}, 32'd0);
        cyc;
        set_in(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        chk("br_valid1", {31'd0, bus.if_valid}, 32'd0);
        chk("br_req1",   {31'd0, bus.imem_req}, 32'd1);
        chk("br_addr1",  bus.imem_addr, 32'h100);
        cyc;
        set_in(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        chk("br_valid2", {31'd0, bus.if_valid}, 32'd1);
        chk("br_pc2",    bus.if_pc,    32'h100);
        chk("br_instr2", bus.if_instr, 32'h100);
        chk("br_addr2",  bus.imem_addr, 32'h104);
        cyc;

        // Not-taken combinations: stream continues sequentially
        set_in(1'b0, 1'b1, 1'b1, 1'b0, 32'h200);
        chk("nt1_req",  {31'd0, bus.imem_req}, 32'd1);
        chk("nt1_addr", bus.imem_addr, 32'h108);
        chk("nt1_pc",   bus.if_pc,     32'h104);
        cyc;
        set_in(1'b0, 1'b1, 1'b0, 1'b1, 32'h200);
        chk("nt2_req",  {31'd0, bus.imem_req}, 32'd1);
        chk("nt2_addr", bus.imem_addr, 32'h10C);
        chk("nt2_pc",   bus.if_pc,     32'h108);
        cyc;
        set_in(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        chk("nt3_addr", bus.imem_addr, 32'h110);
        chk("nt3_pc",   bus.if_pc,     32'h10C);

        // Redirect near the top of the address space, PC wraps to 0
        set_in(1'b0, 1'b1, 1'b1, 1'b1, 32'hFFFF_FFF8);
        chk("wr_req0", {31'd0, bus.imem_req}, 32'd0);
        cyc;
        set_in(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        chk("wr_addr1",  bus.imem_addr, 32'hFFFF_FFF8);
        chk("wr_valid1", {31'd0, bus.if_valid}, 32'd0);
        cyc;
        set_in(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        chk("wr_pc2",   bus.if_pc,     32'hFFFF_FFF8);
        chk("wr_addr2", bus.imem_addr, 32'hFFFF_FFFC);
        cyc;
        set_in(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        chk("wr_pc3",   bus.if_pc,     32'hFFFF_FFFC);
        chk("wr_addr3", bus.imem_addr, 32'h0);
        cyc;
        set_in(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        chk("wr_pc4",    bus.if_pc,    32'h0);
        chk("wr_instr4", bus.if_instr, 32'h0);
        // Reset mid-stream
        set_in(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        chk("mr_valid", {31'd0, bus.if_valid}, 32'd0);
        chk("mr_req",   {31'd0, bus.imem_req}, 32'd0);
        cyc;
        set_in(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        chk("mr_valid1", {31'd0, bus.if_valid}, 32'd0);
        chk("mr_req1",   {31'd0, bus.imem_req}, 32'd1);
        chk("mr_addr1",  bus.imem_addr, 32'h0);
        cyc;
        set_in(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        chk("mr_valid2", {31'd0, bus.if_valid}, 32'd1);
        chk("mr_pc2",    bus.if_pc,     32'h0);
        chk("mr_addr2",  bus.imem_addr, 32'h4);

        // Misaligned redirect halts the stage until reset
        set_in(1'b0, 1'b1, 1'b1, 1'b1, 32'h102);
        chk("ma_req0", {31'd0, bus.imem_req}, 32'd0);
        chk("ma_err0", {31'd0, fetch_err},    32'd0);
        cyc;
        for (int h = 0; h < 3; h++) begin
            set_in(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
            chk("halt_err",   {31'd0, fetch_err},    32'd1);
            chk("halt_req",   {31'd0, bus.imem_req}, 32'd0);
            chk("halt_valid", {31'd0, bus.if_valid}, 32'd0);
            cyc;
        end
        set_in(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        chk("hr_req", {31'd0, bus.imem_req}, 32'd0);
        cyc;
        set_in(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        chk("hr_err",  {31'd0, fetch_err},    32'd0);
        chk("hr_req1", {31'd0, bus.imem_req}, 32'd1);
        chk("hr_addr", bus.imem_addr, 32'h0);
        cyc;
        set_in(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        chk("hr_valid", {31'd0, bus.if_valid}, 32'd1);
        chk("hr_pc",    bus.if_pc, 32'h0);
        cyc;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
`default_nettype wire
